// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer
//   Control stage in front of a free-running 1x1 MAC accumulator. Accepts one
//   dot-product job of len operand pairs, clears the accumulator first, feeds
//   registered operands (zeros on bubbles, since the MAC adds every cycle),
//   then captures the final sum and offers it on a valid/ready result port.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, len         job request and pair count, sampled only in IDLE
//   s_a, s_b, s_valid  operand pair stream; s_ready high while streaming
//   m_a, m_b           registered operands to MAC in_a / in_b
//   acc_clr            to MAC rst; high in CLEAR and while rst is high
//   acc_in             MAC accumulator output
//   res, res_valid     captured result, held until res_ready
//   res_ready          consumer accepts res
//   busy               high in every state except IDLE
//   done               one-cycle pulse after the result handshake
module mac_operand_sequencer #(
  parameter int unsigned N     = 32,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [N-1:0]     s_a,
  input  logic [N-1:0]     s_b,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [N-1:0]     m_a,
  output logic [N-1:0]     m_b,
  output logic             acc_clr,
  input  logic [2*N-1:0]   acc_in,
  output logic [2*N-1:0]   res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN0,
    DRAIN1,
    HOLD
  } state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [LEN_W-1:0] count, count_n;
  logic [LEN_W-1:0] count_inc;
  logic [N-1:0]     m_a_n, m_b_n;
  logic [2*N-1:0]   res_n;
  logic             res_valid_n;
  logic             done_n;

  // count never exceeds len_q, so the increment cannot wrap even at max len
  assign count_inc = count + LEN_W'(1);

  assign s_ready = (state == STREAM);
  assign busy    = (state != IDLE);
  assign acc_clr = rst | (state == CLEAR);

  always_comb begin
    state_n     = state;
    len_n       = len_q;
    count_n     = count;
    m_a_n       = m_a;
    m_b_n       = m_b;
    res_n       = res;
    res_valid_n = res_valid;
    done_n      = 1'b0;

    unique case (state)
      IDLE: begin
        m_a_n = '0;
        m_b_n = '0;
        if (start) begin
          len_n   = len;
          count_n = '0;
          state_n = CLEAR;
        end
      end
      CLEAR: begin
        m_a_n   = '0;
        m_b_n   = '0;
        state_n = (len_q != '0) ? STREAM : DRAIN0;
      end
      STREAM: begin
        if (s_valid) begin
          m_a_n   = s_a;
          m_b_n   = s_b;
          count_n = count_inc;
          if (count_inc == len_q) state_n = DRAIN0;
        end else begin
          // bubble: zero operands so the free-running MAC adds nothing
          m_a_n = '0;
          m_b_n = '0;
        end
      end
      DRAIN0: begin
        // last pair is summed by the MAC at this edge
        m_a_n   = '0;
        m_b_n   = '0;
        state_n = DRAIN1;
      end
      DRAIN1: begin
        res_n       = acc_in;
        res_valid_n = 1'b1;
        state_n     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_n = 1'b0;
          done_n      = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      count     <= '0;
      m_a       <= '0;
      m_b       <= '0;
      res       <= '0;
      res_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      len_q     <= len_n;
      count     <= count_n;
      m_a       <= m_a_n;
      m_b       <= m_b_n;
      res       <= res_n;
      res_valid <= res_valid_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
module tb_mac_operand_sequencer;

  localparam int unsigned N     = 32;
  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [N-1:0]     s_a, s_b;
  logic             s_valid;
  logic             s_ready;
  logic [N-1:0]     m_a, m_b;
  logic             acc_clr;
  logic [2*N-1:0]   acc_in;
  logic [2*N-1:0]   res;
  logic             res_valid;
  logic             res_ready;
  logic             busy;
  logic             done;

  mac_operand_sequencer #(.N(N), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .s_a(s_a), .s_b(s_b), .s_valid(s_valid), .s_ready(s_ready),
    .m_a(m_a), .m_b(m_b), .acc_clr(acc_clr), .acc_in(acc_in),
    .res(res), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Free-running MAC environment model: accumulates every cycle, acc_clr resets it
  logic [2*N-1:0] mac_acc;
  always @(posedge clk) begin
    if (acc_clr) mac_acc <= '0;
    else         mac_acc <= mac_acc + (2*N)'(m_a) * (2*N)'(m_b);
  end
  assign acc_in = mac_acc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int start_cyc = 0;
  int rv_rise_cyc = 0;
  logic rv_prev = 1'b0;
  logic hs_prev = 1'b0;
  logic [2*N-1:0] sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change at posedge+1, so negedge sampling is race-free
  always @(negedge clk) begin
    if (!rst && s_valid && s_ready) acc_cnt++;
  end

  // Monitor: pops expected result at each handshake, checks done timing
  always @(negedge clk) begin
    if (res_valid && res_ready && !rst) begin
      if (sb.size() == 0) chk("unexpected_result", res, 64'hDEAD_DEAD_DEAD_DEAD);
      else                chk("result", res, sb.pop_front());
    end
    chk("done_pulse", {63'b0, done}, {63'b0, hs_prev});
    hs_prev = res_valid && res_ready && !rst;
    if (res_valid && !rv_prev) rv_rise_cyc = cyc;
    rv_prev = res_valid;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LEN_W-1:0] l);
    int t;
    for (t = 0; t < 50 && busy; t++) tick();
    if (busy) chk("start_wait_timeout", 64'd1, 64'd0);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  // Leaves s_valid high so consecutive calls stream back-to-back
  task automatic send_pair(input logic [N-1:0] a, input logic [N-1:0] b);
    bit ok = 0;
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
    for (int t = 0; t < 40; t++) begin
      if (s_ready) begin
        tick();
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) chk("pair_accept_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_idle;
    for (int t = 0; t < 200 && busy; t++) tick();
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int a0;
    logic any_ready;
    rst = 1'b1; start = 1'b0; len = '0; s_a = '0; s_b = '0;
    s_valid = 1'b0; res_ready = 1'b1;
    tick(); tick();
    chk("rst_s_ready", {63'b0, s_ready}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_res_valid", {63'b0, res_valid}, 64'd0);
    chk("rst_acc_clr", {63'b0, acc_clr}, 64'd1);
    chk("rst_m_a", 64'(m_a), 64'd0);
    chk("rst_res", res, 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_acc_clr", {63'b0, acc_clr}, 64'd0);

    // len=4 back-to-back, extra offered pair must not be taken
    a0 = acc_cnt;
    sb.push_back(64'd100);
    do_start(16'd4);
    chk("clear_acc_clr", {63'b0, acc_clr}, 64'd1);
    send_pair(32'd1, 32'd2);
    send_pair(32'd3, 32'd4);
    send_pair(32'd5, 32'd6);
    send_pair(32'd7, 32'd8);
    s_a = 32'd99; s_b = 32'd99;
    chk("s_ready_after_last", {63'b0, s_ready}, 64'd0);
    wait_idle();
    s_valid = 1'b0;
    chk("len4_pairs", 64'(acc_cnt - a0), 64'd4);
    chk("len4_latency", 64'(rv_rise_cyc - start_cyc), 64'd7);

    // len=3 with 2-cycle bubbles: 100+6+16
    a0 = acc_cnt;
    sb.push_back(64'd122);
    do_start(16'd3);
    send_pair(32'd10, 32'd10);
    s_valid = 1'b0; tick();
    chk("bubble_m_a", 64'(m_a), 64'd0);
    chk("bubble_m_b", 64'(m_b), 64'd0);
    tick();
    send_pair(32'd2, 32'd3);
    s_valid = 1'b0; tick();
    chk("bubble2_m_a", 64'(m_a), 64'd0);
    tick();
    send_pair(32'd4, 32'd4);
    s_valid = 1'b0;
    wait_idle();
    chk("len3_pairs", 64'(acc_cnt - a0), 64'd3);

    // back-to-back jobs, accumulator cleared between them
    sb.push_back(64'd26);
    do_start(16'd2);
    send_pair(32'd5, 32'd5);
    send_pair(32'd1, 32'd1);
    s_valid = 1'b0;
    wait_idle();
    sb.push_back(64'd9);
    do_start(16'd1);
    send_pair(32'd3, 32'd3);
    s_valid = 1'b0;
    wait_idle();

    // len=0: no pairs, result 0, s_ready never high
    a0 = acc_cnt;
    sb.push_back(64'd0);
    s_valid = 1'b1; s_a = 32'd7; s_b = 32'd7;
    do_start(16'd0);
    any_ready = 1'b0;
    for (int t = 0; t < 20 && busy; t++) begin
      any_ready |= s_ready;
      tick();
    end
    s_valid = 1'b0;
    chk("len0_s_ready", {63'b0, any_ready}, 64'd0);
    chk("len0_pairs", 64'(acc_cnt - a0), 64'd0);
    chk("len0_latency", 64'(rv_rise_cyc - start_cyc), 64'd3);

    // stall in HOLD, start ignored
    res_ready = 1'b0;
    sb.push_back(64'd6);
    do_start(16'd1);
    send_pair(32'd2, 32'd3);
    s_valid = 1'b0;
    for (int t = 0; t < 20 && !res_valid; t++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_res", res, 64'd6);
      chk("hold_res_valid", {63'b0, res_valid}, 64'd1);
      start = (i == 2);
      len = 16'd5;
      tick();
    end
    start = 1'b0;
    res_ready = 1'b1;
    tick();
    chk("post_hs_res_valid", {63'b0, res_valid}, 64'd0);
    chk("post_hs_res_kept", res, 64'd6);
    tick(); tick();
    chk("start_in_hold_ignored", {63'b0, busy}, 64'd0);

    // reset mid-STREAM after 2 of 4 pairs
    do_start(16'd4);
    send_pair(32'd9, 32'd9);
    send_pair(32'd9, 32'd9);
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_s_ready", {63'b0, s_ready}, 64'd0);
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    chk("midrst_acc_clr", {63'b0, acc_clr}, 64'd1);
    chk("midrst_m_a", 64'(m_a), 64'd0);
    chk("midrst_res", res, 64'd0);
    rst = 1'b0;
    tick();
    sb.push_back(64'hFFFF_FFFE_0000_0001);
    do_start(16'd1);
    send_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    s_valid = 1'b0;
    wait_idle();
    tick(); tick();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
